// File: rtl/rb_ctrl_pkg.sv
// rb_ctrl_pkg: shared types and sizing helpers for the row-buffer window controller.
package rb_ctrl_pkg;

    // Controller sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Default frame geometry (LeNet5 first layer: 32x32 input, 5x5 kernel)
    localparam int DEF_COLS  = 32;
    localparam int DEF_ROWS  = 32;
    localparam int DEF_KSIZE = 5;

    // Counter width for a modulo-n counter; never narrower than one bit
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_COL_W = cnt_w(DEF_COLS);
    localparam int DEF_ROW_W = cnt_w(DEF_ROWS);

endpackage

// File: rtl/rb_pos_counter.sv
// rb_pos_counter: wrapping column/row position counter for the input pixel stream.
// col advances on every inc; on column wrap the row advances, and the row wraps at ROWS-1.
module rb_pos_counter
    import rb_ctrl_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     inc,
    output logic [cnt_w(COLS)-1:0]   col,
    output logic [cnt_w(ROWS)-1:0]   row,
    output logic                     last_col,
    output logic                     last_row
);

    localparam int COL_W = cnt_w(COLS);
    localparam int ROW_W = cnt_w(ROWS);

    logic [COL_W-1:0] col_d, col_q;
    logic [ROW_W-1:0] row_d, row_q;

    assign last_col = (col_q == COL_W'(COLS - 1));
    assign last_row = (row_q == ROW_W'(ROWS - 1));
    assign col      = col_q;
    assign row      = row_q;

    // Next position: clear wins over increment, column wrap carries into the row
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clr) begin
            col_d = {COL_W{1'b0}};
            row_d = {ROW_W{1'b0}};
        end else if (inc) begin
            if (last_col) begin
                col_d = {COL_W{1'b0}};
                if (last_row) begin
                    row_d = {ROW_W{1'b0}};
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end else begin
                col_d = col_q + COL_W'(1);
                row_d = row_q;
            end
        end else begin
            col_d = col_q;
            row_d = row_q;
        end
    end

    // Position registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= {COL_W{1'b0}};
            row_q <= {ROW_W{1'b0}};
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/rb_window_ctrl.sv
// rb_window_ctrl: sequencing controller for the (KSIZE-1)-deep row-buffer chain that
// feeds the KSIZE x KSIZE convolution window. Accepts pixels over valid/ready, drives
// the row-buffer shift enable, and flags complete windows with their output-map position.
// Optional build macro RBCTRL_PERF_EN adds a 16-bit saturating stall-cycle counter.
module rb_window_ctrl
    import rb_ctrl_pkg::*;
#(
    parameter int COLS  = DEF_COLS,
    parameter int ROWS  = DEF_ROWS,
    parameter int KSIZE = DEF_KSIZE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    rb_en,
    output logic                    win_valid,
    input  logic                    win_ready,
    output logic [cnt_w(ROWS)-1:0]  out_row,
    output logic [cnt_w(COLS)-1:0]  out_col,
    output logic                    busy,
    output logic                    frame_done
`ifdef RBCTRL_PERF_EN
    ,
    output logic [15:0]             stall_cnt
`endif
);

    localparam int COL_W = cnt_w(COLS);
    localparam int ROW_W = cnt_w(ROWS);

    state_e           state_d, state_q;
    logic             win_valid_d, win_valid_q;
    logic [ROW_W-1:0] out_row_d, out_row_q;
    logic [COL_W-1:0] out_col_d, out_col_q;
    logic             frame_done_d, frame_done_q;

    logic             accept_s;
    logic             in_ready_s;
    logic             cnt_clr_s;
    logic             win_fire_s;
    logic             first_win_s;
    logic [COL_W-1:0] col_s;
    logic [ROW_W-1:0] row_s;
    logic             last_col_s;
    logic             last_row_s;

    rb_pos_counter #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_pos (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr_s),
        .inc      (accept_s),
        .col      (col_s),
        .row      (row_s),
        .last_col (last_col_s),
        .last_row (last_row_s)
    );

    // A pending window that is not being consumed blocks the stream so the buffers hold
    assign in_ready_s  = ((state_q == FILL) || (state_q == RUN)) && (!win_valid_q || win_ready);
    assign accept_s    = in_valid && in_ready_s;
    // Pixel (r,c) completes a window once KSIZE-1 rows are buffered and c reaches KSIZE-1;
    // the c<KSIZE-1 case would straddle a row wrap and is dropped
    assign win_fire_s  = accept_s && (row_s >= ROW_W'(KSIZE - 1)) && (col_s >= COL_W'(KSIZE - 1));
    assign first_win_s = (row_s == ROW_W'(KSIZE - 1)) && (col_s == COL_W'(KSIZE - 1));

    assign in_ready   = in_ready_s;
    assign rb_en      = accept_s;
    assign win_valid  = win_valid_q;
    assign out_row    = out_row_q;
    assign out_col    = out_col_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = frame_done_q;

    // Next-state, counter clear and end-of-frame pulse
    always_comb begin
        state_d      = state_q;
        cnt_clr_s    = 1'b0;
        frame_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_clr_s = 1'b1;
                if (start) begin
                    state_d = FILL;
                end else begin
                    state_d = IDLE;
                end
            end
            FILL: begin
                if (accept_s && first_win_s) begin
                    state_d = RUN;
                end else begin
                    state_d = FILL;
                end
            end
            RUN: begin
                if (accept_s && last_col_s && last_row_s) begin
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (!win_valid_q || win_ready) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Window-valid flag and its output-map coordinates; a new window overrides a consume
    always_comb begin
        win_valid_d = win_valid_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        if (win_fire_s) begin
            win_valid_d = 1'b1;
            out_row_d   = row_s - ROW_W'(KSIZE - 1);
            out_col_d   = col_s - COL_W'(KSIZE - 1);
        end else if (win_ready) begin
            win_valid_d = 1'b0;
        end else begin
            win_valid_d = win_valid_q;
        end
    end

    // Controller state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            win_valid_q  <= 1'b0;
            out_row_q    <= {ROW_W{1'b0}};
            out_col_q    <= {COL_W{1'b0}};
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_valid_q  <= win_valid_d;
            out_row_q    <= out_row_d;
            out_col_q    <= out_col_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef RBCTRL_PERF_EN
    logic [15:0] stall_cnt_d, stall_cnt_q;

    assign stall_cnt = stall_cnt_q;

    // Count backpressure cycles, saturating; restart on each new frame
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == IDLE) && start) begin
            stall_cnt_d = 16'h0000;
        end else if (win_valid_q && !win_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'h0001;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 16'h0000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_rb_window_ctrl.sv
// tb_rb_window_ctrl: directed self-checking bench for rb_window_ctrl at default geometry
// (32x32 frame, 5x5 window). Build with RBCTRL_PERF_EN to also check stall_cnt.
module tb_rb_window_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic       rb_en;
    logic       win_valid;
    logic       win_ready;
    logic [4:0] out_row;
    logic [4:0] out_col;
    logic       busy;
    logic       frame_done;
`ifdef RBCTRL_PERF_EN
    logic [15:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    rb_window_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .rb_en      (rb_en),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .out_row    (out_row),
        .out_col    (out_col),
        .busy       (busy),
        .frame_done (frame_done)
`ifdef RBCTRL_PERF_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Streams one frame and checks every cycle against a small behavioural model.
    // rst_at >= 0 aborts the frame with a reset once that many pixels were accepted.
    task automatic run_frame(input bit stall_en, input bit toggle_en, input bit start_mid,
                             input int rst_at,
                             output int wins, output int first_pix, output int first_r,
                             output int first_c, output int last_r, output int last_c,
                             output int fd_cnt, output int stall_cycles);
        int m_acc, mr, mc, exp_or, exp_oc, stall_left, tail;
        bit m_run, m_done, exp_wv, exp_fd, exp_in_ready, acc, nfd, stall_done, fd_given, finished;
        wins = 0; first_pix = -1; first_r = -1; first_c = -1; last_r = -1; last_c = -1;
        fd_cnt = 0; stall_cycles = 0;
        m_acc = 0; mr = 0; mc = 0; exp_or = 0; exp_oc = 0; stall_left = 0; tail = 0;
        m_run = 1'b1; m_done = 1'b0; exp_wv = 1'b0; exp_fd = 1'b0;
        stall_done = 1'b0; fd_given = 1'b0; finished = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; in_valid = 1'b0; win_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 6000 && !finished; cyc++) begin
            if (rst_at >= 0 && m_acc == rst_at) begin
                rst = 1'b1;
                #1;
                n_checks++;
                if ({in_ready, rb_en, win_valid, busy, frame_done} !== 5'b00000 ||
                    out_row !== 5'd0 || out_col !== 5'd0) begin
                    n_fail++;
                    $display("FAIL rst_mid_outputs: got rdy/en/wv/busy/fd=%b%b%b%b%b row=%0d col=%0d, want all 0",
                             in_ready, rb_en, win_valid, busy, frame_done, out_row, out_col);
                end
                @(negedge clk);
                rst = 1'b0;
                in_valid = 1'b0;
                return;
            end
            if (stall_en && !stall_done && win_valid === 1'b1 && out_row == 5'd3 && out_col == 5'd5) begin
                stall_left = 10;
                stall_done = 1'b1;
            end
            win_ready = (stall_left > 0) ? 1'b0 : 1'b1;
            in_valid  = (toggle_en && stall_left == 0) ? cyc[0] : 1'b1;
            start     = (start_mid && m_acc == 300) ? 1'b1 : 1'b0;
            @(negedge clk);
            exp_in_ready = m_run && (!exp_wv || win_ready);
            n_checks++;
            if (in_ready !== exp_in_ready) begin
                n_fail++;
                $display("FAIL in_ready @pix %0d: got %b want %b", m_acc, in_ready, exp_in_ready);
            end
            n_checks++;
            if (rb_en !== (in_valid && exp_in_ready)) begin
                n_fail++;
                $display("FAIL rb_en @pix %0d: got %b want %b", m_acc, rb_en, in_valid && exp_in_ready);
            end
            n_checks++;
            if (win_valid !== exp_wv) begin
                n_fail++;
                $display("FAIL win_valid @pix %0d: got %b want %b", m_acc, win_valid, exp_wv);
            end
            if (exp_wv) begin
                n_checks++;
                if (out_row !== 5'(exp_or) || out_col !== 5'(exp_oc)) begin
                    n_fail++;
                    $display("FAIL win_coord @pix %0d: got (%0d,%0d) want (%0d,%0d)",
                             m_acc, out_row, out_col, exp_or, exp_oc);
                end
            end
            n_checks++;
            if (frame_done !== exp_fd) begin
                n_fail++;
                $display("FAIL frame_done @pix %0d: got %b want %b", m_acc, frame_done, exp_fd);
            end
            n_checks++;
            if (busy !== (m_run || m_done)) begin
                n_fail++;
                $display("FAIL busy @pix %0d: got %b want %b", m_acc, busy, m_run || m_done);
            end
            if (win_valid === 1'b1 && win_ready) begin
                wins++;
                if (first_pix < 0) begin
                    first_pix = m_acc - 1;
                    first_r   = int'(out_row);
                    first_c   = int'(out_col);
                end
                last_r = int'(out_row);
                last_c = int'(out_col);
            end
            if (stall_left > 0) begin
                stall_cycles++;
                stall_left--;
            end
            if (frame_done === 1'b1) fd_cnt++;
            if (fd_given) begin
                tail++;
                if (tail >= 3) finished = 1'b1;
            end
            if (exp_fd) fd_given = 1'b1;
            // Model of the clock edge that follows
            acc = in_valid && exp_in_ready;
            nfd = m_done && (!exp_wv || win_ready);
            if (nfd) m_done = 1'b0;
            if (acc) begin
                if (mr >= 4 && mc >= 4) begin
                    exp_wv = 1'b1;
                    exp_or = mr - 4;
                    exp_oc = mc - 4;
                end else if (win_ready) begin
                    exp_wv = 1'b0;
                end
                if (mc == 31) begin
                    mc = 0;
                    mr = mr + 1;
                end else begin
                    mc = mc + 1;
                end
                m_acc++;
                if (m_acc == 1024) begin
                    m_run  = 1'b0;
                    m_done = 1'b1;
                end
            end else if (win_ready) begin
                exp_wv = 1'b0;
            end
            exp_fd = nfd;
            @(posedge clk); #1;
        end
        start = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if (!finished) begin
            n_fail++;
            $display("FAIL frame_timeout: accepted %0d of 1024 pixels", m_acc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b1; win_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({in_ready, rb_en, win_valid, busy, frame_done} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_flags: got rdy/en/wv/busy/fd=%b%b%b%b%b want 00000",
                     in_ready, rb_en, win_valid, busy, frame_done);
        end
        n_checks++;
        if (out_row !== 5'd0 || out_col !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_coords: got (%0d,%0d) want (0,0)", out_row, out_col);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0 || rb_en !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_accept: got rdy=%b en=%b busy=%b want 0 0 0", in_ready, rb_en, busy);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_stream();
        int wins, fp, fr, fc, lr, lc, fd, sc;
        run_frame(1'b0, 1'b0, 1'b0, -1, wins, fp, fr, fc, lr, lc, fd, sc);
        n_checks++;
        if (wins != 784) begin n_fail++; $display("FAIL stream_wins: got %0d want 784", wins); end
        n_checks++;
        if (fp != 132) begin n_fail++; $display("FAIL stream_first_pix: got %0d want 132", fp); end
        n_checks++;
        if (fr != 0 || fc != 0) begin n_fail++; $display("FAIL stream_first_win: got (%0d,%0d) want (0,0)", fr, fc); end
        n_checks++;
        if (lr != 27 || lc != 27) begin n_fail++; $display("FAIL stream_last_win: got (%0d,%0d) want (27,27)", lr, lc); end
        n_checks++;
        if (fd != 1) begin n_fail++; $display("FAIL stream_frame_done: got %0d pulses want 1", fd); end
    endtask

    task automatic test_backpressure();
        int wins, fp, fr, fc, lr, lc, fd, sc;
        run_frame(1'b1, 1'b0, 1'b0, -1, wins, fp, fr, fc, lr, lc, fd, sc);
        n_checks++;
        if (sc != 10) begin n_fail++; $display("FAIL stall_cycles: got %0d want 10", sc); end
        n_checks++;
        if (wins != 784) begin n_fail++; $display("FAIL stall_wins: got %0d want 784", wins); end
        n_checks++;
        if (fd != 1) begin n_fail++; $display("FAIL stall_frame_done: got %0d want 1", fd); end
`ifdef RBCTRL_PERF_EN
        n_checks++;
        if (stall_cnt !== 16'd10) begin n_fail++; $display("FAIL stall_cnt: got %0d want 10", stall_cnt); end
`endif
    endtask

    task automatic test_toggle_valid();
        int wins, fp, fr, fc, lr, lc, fd, sc;
        run_frame(1'b0, 1'b1, 1'b0, -1, wins, fp, fr, fc, lr, lc, fd, sc);
        n_checks++;
        if (wins != 784) begin n_fail++; $display("FAIL toggle_wins: got %0d want 784", wins); end
        n_checks++;
        if (lr != 27 || lc != 27) begin n_fail++; $display("FAIL toggle_last_win: got (%0d,%0d) want (27,27)", lr, lc); end
    endtask

    task automatic test_start_in_run();
        int wins, fp, fr, fc, lr, lc, fd, sc;
        run_frame(1'b0, 1'b0, 1'b1, -1, wins, fp, fr, fc, lr, lc, fd, sc);
        n_checks++;
        if (wins != 784) begin n_fail++; $display("FAIL start_run_wins: got %0d want 784", wins); end
        n_checks++;
        if (fd != 1) begin n_fail++; $display("FAIL start_run_frame_done: got %0d want 1", fd); end
    endtask

    task automatic test_rst_mid_frame();
        int wins, fp, fr, fc, lr, lc, fd, sc;
        run_frame(1'b0, 1'b0, 1'b0, 500, wins, fp, fr, fc, lr, lc, fd, sc);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || win_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_idle: got busy=%b wv=%b want 0 0", busy, win_valid);
        end
        run_frame(1'b0, 1'b0, 1'b0, -1, wins, fp, fr, fc, lr, lc, fd, sc);
        n_checks++;
        if (fr != 0 || fc != 0 || fp != 132) begin
            n_fail++;
            $display("FAIL restart_first_win: got (%0d,%0d) at pix %0d want (0,0) at 132", fr, fc, fp);
        end
        n_checks++;
        if (wins != 784) begin n_fail++; $display("FAIL restart_wins: got %0d want 784", wins); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_toggle_valid();
        test_start_in_run();
        test_rst_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
